// File: rtl/step_ctrl.sv
// step_ctrl: run/halt/single-step controller for the pipeline core. Conditions the
// asynchronous debug inputs, sequences RUN/HALT/STEP and counts enabled cycles.

module step_ctrl_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic evt
);
    localparam int CW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;

    logic [SYNC_STAGES-1:0] sync_p0;
    logic [CW-1:0]          run_cnt_p1;
    logic                   lvl_p1;
    logic                   lvl_p2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0    <= '0;
            run_cnt_p1 <= '0;
            lvl_p1     <= 1'b0;
            lvl_p2     <= 1'b0;
        end else begin
            // p0: synchronizer chain
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
            // p1: level accepted only after FILT_CYC consecutive mismatching samples
            if (sync_p0[SYNC_STAGES-1] == lvl_p1) begin
                run_cnt_p1 <= '0;
            end else if (run_cnt_p1 == CW'(FILT_CYC - 1)) begin
                lvl_p1     <= sync_p0[SYNC_STAGES-1];
                run_cnt_p1 <= '0;
            end else begin
                run_cnt_p1 <= run_cnt_p1 + CW'(1);
            end
            // p2: delayed level for rising-edge detection
            lvl_p2 <= lvl_p1;
        end
    end

    assign evt = lvl_p1 & ~lvl_p2;
endmodule

module step_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             change,
    input  logic             step,
    input  logic             brk,
    output logic             pipe_en,
    output logic             mode,
    output logic             step_ack,
    output logic             brk_hit,
    output logic [CNT_W-1:0] cycle_cnt
);
    typedef enum logic [1:0] {RUN, HALT, STEP} state_t;

    state_t state;
    logic   chg_evt;
    logic   stp_evt;
    logic   brk_evt;
    logic   brk_q;
    logic   pend;

    step_ctrl_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) u_chg (
        .clock (clock),
        .reset (reset),
        .din   (change),
        .evt   (chg_evt)
    );

    step_ctrl_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) u_stp (
        .clock (clock),
        .reset (reset),
        .din   (step),
        .evt   (stp_evt)
    );

    // brk is already synchronous to clock; only an edge detector is needed
    assign brk_evt = brk & ~brk_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            pipe_en   <= 1'b1;
            mode      <= 1'b1;
            step_ack  <= 1'b0;
            brk_hit   <= 1'b0;
            pend      <= 1'b0;
            brk_q     <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            brk_q <= brk;
            if (pipe_en) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            case (state)
                RUN: begin
                    if (chg_evt || brk_evt) begin
                        state   <= HALT;
                        pipe_en <= 1'b0;
                        mode    <= 1'b0;
                        if (brk_evt) begin
                            brk_hit <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    // a change latched during STEP outranks a fresh step request
                    if (chg_evt || pend) begin
                        state   <= RUN;
                        pipe_en <= 1'b1;
                        mode    <= 1'b1;
                        brk_hit <= 1'b0;
                        pend    <= 1'b0;
                    end else if (stp_evt) begin
                        state    <= STEP;
                        pipe_en  <= 1'b1;
                        step_ack <= 1'b1;
                    end
                end
                STEP: begin
                    state    <= HALT;
                    pipe_en  <= 1'b0;
                    step_ack <= 1'b0;
                    if (chg_evt) begin
                        pend <= 1'b1;
                    end
                end
                default: begin
                    state    <= HALT;
                    pipe_en  <= 1'b0;
                    mode     <= 1'b0;
                    step_ack <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_step_ctrl.sv
// Bench for step_ctrl: directed debug-input sequences checked against an
// abstract per-edge model plus hand-computed expectations.

module tb_step_ctrl;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_CYC    = 2;
    localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2;

    logic        clock  = 1'b0;
    logic        reset  = 1'b1;
    logic        change = 1'b0;
    logic        step   = 1'b0;
    logic        brk    = 1'b0;
    logic        pipe_en, mode, step_ack, brk_hit;
    logic [31:0] cycle_cnt;
    logic        pe4, md4, sa4, bh4;
    logic [3:0]  cnt4;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    step_ctrl #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .change(change), .step(step), .brk(brk),
        .pipe_en(pipe_en), .mode(mode), .step_ack(step_ack), .brk_hit(brk_hit),
        .cycle_cnt(cycle_cnt)
    );

    step_ctrl #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .change(change), .step(step), .brk(brk),
        .pipe_en(pe4), .mode(md4), .step_ack(sa4), .brk_hit(bh4), .cycle_cnt(cnt4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: sample histories for the two debug inputs (index 0 change, 1 step)
    bit          raw [2][SYNC_STAGES];
    bit          fil [2][FILT_CYC];
    bit          acc [2];
    bit          accd[2];
    bit          brk_d;
    int          m_st;
    bit          m_pend, m_hit;
    logic [31:0] m_cnt;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < SYNC_STAGES; i++) raw[k][i] = 1'b0;
            for (int i = 0; i < FILT_CYC; i++) fil[k][i] = 1'b0;
            acc[k]  = 1'b0;
            accd[k] = 1'b0;
        end
        brk_d  = 1'b0;
        m_st   = M_RUN;
        m_pend = 1'b0;
        m_hit  = 1'b0;
        m_cnt  = '0;
    endtask

    task automatic cond_edge(input int k, input bit sample, output bit evt);
        bit synced, differ;
        evt    = acc[k] & ~accd[k];
        synced = raw[k][0];
        for (int i = 0; i < SYNC_STAGES - 1; i++) raw[k][i] = raw[k][i+1];
        raw[k][SYNC_STAGES-1] = sample;
        for (int i = 0; i < FILT_CYC - 1; i++) fil[k][i] = fil[k][i+1];
        fil[k][FILT_CYC-1] = synced;
        differ = 1'b1;
        for (int i = 0; i < FILT_CYC; i++) if (fil[k][i] == acc[k]) differ = 1'b0;
        accd[k] = acc[k];
        if (differ) acc[k] = ~acc[k];
    endtask

    task automatic model_edge();
        bit ce, se, be, en_old;
        en_old = (m_st != M_HALT);
        cond_edge(0, change, ce);
        cond_edge(1, step, se);
        be    = brk & ~brk_d;
        brk_d = brk;
        if (m_st == M_RUN) begin
            if (ce || be) m_st = M_HALT;
            if (be) m_hit = 1'b1;
        end else if (m_st == M_HALT) begin
            if (ce || m_pend) begin
                m_st = M_RUN; m_hit = 1'b0; m_pend = 1'b0;
            end else if (se) m_st = M_STEP;
        end else begin
            if (ce) m_pend = 1'b1;
            m_st = M_HALT;
        end
        if (en_old) m_cnt = m_cnt + 1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) model_reset();
            else model_edge();
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("flags", {pipe_en, mode, step_ack, brk_hit},
                    {m_st != M_HALT, m_st == M_RUN, m_st == M_STEP, m_hit});
                chk("cycle_cnt", cycle_cnt, m_cnt);
                chk("cnt4_inst", {pe4, md4, sa4, bh4, cnt4},
                    {m_st != M_HALT, m_st == M_RUN, m_st == M_STEP, m_hit, m_cnt[3:0]});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_chg(input int len);
        change = 1'b1;
        cyc(len);
        change = 1'b0;
    endtask

    task automatic win(input int n, input int hold, output int acks, output int ens);
        acks = 0;
        ens  = 0;
        if (hold > 0) step = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (i == hold - 1) step = 1'b0;
            acks += int'(step_ack);
            ens  += int'(pipe_en);
        end
    endtask

    initial begin
        int acks, ens;
        logic [31:0] base;

        cyc(2);
        chk("rst_flags", {pipe_en, mode, step_ack, brk_hit}, 4'b1100);
        chk("rst_cnt", cycle_cnt, 0);
        reset = 1'b0;
        cyc(10);
        chk("cnt_after_10", cycle_cnt, 10);

        // change held 3 cycles: state flips on the fifth edge
        change = 1'b1; cyc(3); change = 1'b0; cyc(1);
        chk("halt_not_yet", pipe_en, 1'b1);
        cyc(1);
        chk("halt_pe_mode", {pipe_en, mode}, 2'b00);
        chk("halt_cnt", cycle_cnt, 15);
        cyc(10);
        chk("cnt_frozen", cycle_cnt, 15);
        pulse_chg(3); cyc(5);
        chk("back_run", {mode, brk_hit}, 2'b10);
        pulse_chg(3); cyc(5);
        chk("halt_again", mode, 1'b0);

        base = cycle_cnt;
        win(25, 4, acks, ens);
        chk("step4_acks", acks, 1);
        chk("step4_ens", ens, 1);
        chk("step4_cnt", cycle_cnt, base + 1);
        win(30, 20, acks, ens);
        chk("step20_acks", acks, 1);
        chk("step20_mode", mode, 1'b0);

        // sub-period glitch on change, 1-cycle step pulse
        #2 change = 1'b1;
        #1 change = 1'b0;
        @(negedge clock);
        base = cycle_cnt;
        win(15, 1, acks, ens);
        chk("glitch_ens", ens, 0);
        chk("glitch_state", {mode, cycle_cnt}, {1'b0, base});

        pulse_chg(3); cyc(5);
        chk("run_for_brk", mode, 1'b1);
        brk = 1'b1; cyc(1);
        chk("brk_halt", {pipe_en, mode, brk_hit}, 3'b001);
        pulse_chg(3); cyc(5);
        chk("brk_clear", {mode, brk_hit}, 2'b10);
        cyc(10);
        chk("brk_held_no_rehalt", mode, 1'b1);
        brk = 1'b0; cyc(1); brk = 1'b1; cyc(1);
        chk("brk_rehalt", {pipe_en, brk_hit}, 2'b01);

        // change and step events in the same HALT cycle
        change = 1'b1; step = 1'b1;
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (i == 2) begin change = 1'b0; step = 1'b0; end
            acks += int'(step_ack);
        end
        chk("chg_stp_no_step", acks, 0);
        chk("chg_stp_run", mode, 1'b1);
        brk = 1'b0;

        // change arriving during STEP: STEP, HALT, RUN
        pulse_chg(3); cyc(5);
        chk("halt_for_pend", mode, 1'b0);
        step = 1'b1; cyc(1);
        change = 1'b1; cyc(3);
        step = 1'b0; change = 1'b0; cyc(1);
        chk("pend_step", {pipe_en, step_ack, mode}, 3'b110);
        cyc(1);
        chk("pend_halt", {pipe_en, step_ack, mode}, 3'b000);
        cyc(1);
        chk("pend_run", {pipe_en, mode}, 2'b11);

        // reset in the middle of a STEP cycle with brk_hit set
        cyc(3);
        brk = 1'b1; cyc(1); brk = 1'b0;
        step = 1'b1; cyc(4); step = 1'b0; cyc(1);
        chk("pre_rst_step", {step_ack, brk_hit}, 2'b11);
        #1 reset = 1'b1;
        #1;
        chk("midstep_rst_flags", {pipe_en, mode, step_ack, brk_hit}, 4'b1100);
        chk("midstep_rst_cnt", {cycle_cnt, cnt4}, 36'h0);
        cyc(2);
        reset = 1'b0;
        cyc(15);
        chk("cnt4_at_15", cnt4, 4'd15);
        cyc(1);
        chk("cnt4_wrap", cnt4, 4'd0);
        chk("cnt32_16", cycle_cnt, 16);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/step_ctrl.md
# step_ctrl

Run/halt/single-step controller sitting between the board-level debug inputs (`change`, `step`) and the `pipeline` core. It synchronizes and de-glitches the asynchronous debug inputs, runs a RUN/HALT/STEP state machine, and drives a clock-enable that gates every architectural register update in the pipeline. It also accepts a breakpoint request from the pipeline and keeps a count of enabled cycles for debug readout.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops per debug input, minimum 2.
- `FILT_CYC`, default 2: consecutive cycles a synchronized input must hold a new level before it is accepted, minimum 1.
- `CNT_W`, default 32: width of `cycle_cnt`.

- `clock` in 1: single clock for the block.
- `reset` in 1: asynchronous active-high reset.
- `change` in 1: asynchronous mode-toggle request; rising edge toggles RUN/HALT.
- `step` in 1: asynchronous single-step request; rising edge in HALT advances the pipeline one cycle.
- `brk` in 1: breakpoint request from the pipeline, synchronous to `clock`; rising edge while running halts.
- `pipe_en` out 1: pipeline clock-enable.
- `mode` out 1: 1 = RUN, 0 = HALT or STEP.
- `step_ack` out 1: one-cycle pulse coincident with the single enabled STEP cycle.
- `brk_hit` out 1: sticky flag, halted by breakpoint.
- `cycle_cnt` out CNT_W: number of cycles with `pipe_en`=1 since reset.

## Operation
- Input conditioning, applied separately to `change` and `step`:
  - SYNC_STAGES-flop synchronizer.
  - Filter: the accepted level updates only after the synchronizer output has differed from it for FILT_CYC consecutive cycles. Any mismatch run shorter than that is discarded.
  - Edge detect: a 0→1 transition of the accepted level produces a one-cycle event (`chg_evt`, `stp_evt`).
- `brk` is not synchronized. A registered copy provides edge detection, and `brk_evt` = `brk` & ~`brk_q`.
- States: RUN, HALT, STEP. All outputs decode from registered state or counters; there are no combinational input→output paths.
  - RUN: `pipe_en`=1, `mode`=1.
    - `chg_evt` or `brk_evt` moves to HALT.
    - `brk_evt` also sets `brk_hit`.
    - Both in the same cycle: HALT, and `brk_hit` is set.
    - `stp_evt` is ignored.
  - HALT: `pipe_en`=0, `mode`=0.
    - `chg_evt` moves to RUN and clears `brk_hit`.
    - Otherwise `stp_evt` moves to STEP.
    - `chg_evt` and `stp_evt` in the same cycle: change wins and the step is dropped.
    - `brk_evt` is ignored.
  - STEP: `pipe_en`=1, `step_ack`=1, `mode`=0, for exactly one cycle, then unconditionally HALT.
    - A `chg_evt` arriving in STEP is latched in a one-deep pending flag and acts in the following HALT cycle (HALT→RUN). The pending flag takes priority over a new `stp_evt` in that cycle.
    - `stp_evt` and `brk_evt` in STEP are ignored.
- `cycle_cnt`: increments by 1 on every edge where `pipe_en`=1, and wraps from 2^CNT_W−1 to 0 with no flag.
- Reset values:
  - State RUN, so `pipe_en`=1, `mode`=1.
  - `step_ack`=0, `brk_hit`=0, `cycle_cnt`=0.
  - All synchronizer, filter, edge and pending registers are 0, so an input already high at reset release produces no event.
- Reset asserted mid-STEP or mid-filter: everything returns to the reset values immediately, and no step or toggle is delivered.

## Timing
- Input latency L = SYNC_STAGES + FILT_CYC + 1 rising edges, counted from the first edge that samples the new input level to the edge where the state and `pipe_en` change. With the defaults, L = 5.
- Minimum accepted input pulse: high for at least SYNC_STAGES−1+FILT_CYC full cycles. Shorter pulses may be dropped, and a pulse shorter than one period is never guaranteed to register.
- `brk` latency: the edge after `brk` rises has state HALT, so `pipe_en`=0 in the next cycle. The pipeline cycle in which `brk` rose is therefore the last enabled cycle.
- STEP pulse: `pipe_en`, `step_ack` and the `cycle_cnt` increment occur in the same single cycle.
- Back-to-back steps: `step` must return low for the filter to re-arm, so consecutive steps are at least 2·FILT_CYC+2 cycles apart.

## Test plan
- Reset release, inputs low: `pipe_en`=1, `mode`=1, and `cycle_cnt` reads 10 after 10 edges.
- `change` high for 3 cycles in RUN: exactly 5 edges later `pipe_en`=0, `mode`=0, and `cycle_cnt` freezes. Pulse `change` again: back to RUN with `brk_hit`=0.
- HALT, one `step` pulse of 4 cycles: exactly one cycle with `pipe_en`=1 and `step_ack`=1, `cycle_cnt` +1, then HALT. Holding `step` high for 20 cycles still yields exactly one step.
- HALT, a 1 ns glitch on `change` and a 1-cycle pulse on `step`: no state change and no `pipe_en` pulse.
- RUN, `brk`=1 held high: HALT after 1 edge, `brk_hit`=1. `change` pulse → RUN with `brk_hit`=0, and no re-halt while `brk` stays high. `brk` low then high → HALT again.
- Corner cases:
  - `chg_evt` and `stp_evt` in the same HALT cycle → RUN with no STEP cycle.
  - `chg_evt` during STEP → STEP, HALT, then RUN.
  - `CNT_W`=4 with `cycle_cnt` at 15 → 0 on the next enabled edge.
  - `reset` pulsed mid-STEP → all outputs at reset values immediately.
